// File: rtl/eqcmp_seq_ctrl.sv
// eqcmp: single-chunk equality comparator, purely combinational.
// Latency: 0 cycles (result valid in the same cycle as the inputs).
// Backpressure: none; it evaluates whatever is on its inputs every cycle.
module eqcmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_eq
);

    assign o_eq = (i_a == i_b);

endmodule

// eqcmp_seq_ctrl: wide equality check, one WIDTH-bit chunk per cycle, early exit on first mismatch.
// Latency: done at k+2 cycles after the start edge for a mismatch at chunk k, CHUNKS+1 for a full match.
// Backpressure: start is ignored (not queued) while busy; abort cancels a RUN without a done pulse.
module eqcmp_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [WIDTH*CHUNKS-1:0]       op_a,
    input  logic [WIDTH*CHUNKS-1:0]       op_b,
    output logic                          busy,
    output logic                          done,
    output logic                          equal,
    output logic [$clog2(CHUNKS)-1:0]     mismatch_idx
);

    localparam int IDX_W = $clog2(CHUNKS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                   r_state;
    logic [CHUNKS-1:0][WIDTH-1:0] r_op_a;
    logic [CHUNKS-1:0][WIDTH-1:0] r_op_b;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_equal;
    logic [IDX_W-1:0]             r_mismatch_idx;

    logic [WIDTH-1:0]             w_chunk_a;
    logic [WIDTH-1:0]             w_chunk_b;
    logic                         w_chunk_eq;
    logic                         w_last;

    // The comparator only ever sees the latched copies, so live operand changes are invisible.
    assign w_chunk_a = r_op_a[r_idx];
    assign w_chunk_b = r_op_b[r_idx];
    assign w_last    = (r_idx == IDX_W'(CHUNKS - 1));

    eqcmp #(
        .WIDTH (WIDTH)
    ) u_eqcmp (
        .i_a  (w_chunk_a),
        .i_b  (w_chunk_b),
        .o_eq (w_chunk_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_idx          <= '0;
            r_equal        <= 1'b0;
            r_mismatch_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_a  <= op_a;
                        r_op_b  <= op_b;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort outranks the compare result and leaves the previous result untouched.
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (!w_chunk_eq) begin
                        r_equal        <= 1'b0;
                        r_mismatch_idx <= r_idx;
                        r_state        <= S_DONE;
                    end else if (w_last) begin
                        r_equal        <= 1'b1;
                        r_mismatch_idx <= '0;
                        r_state        <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign equal        = r_equal;
    assign mismatch_idx = r_mismatch_idx;

endmodule

// File: tb/tb_eqcmp_seq_ctrl.sv
// Randomized bench for eqcmp_seq_ctrl against a chunk-scan reference model.
module tb_eqcmp_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int CHUNKS = 4;
    localparam int IDX_W  = 2;
    localparam int OPW    = WIDTH * CHUNKS;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic             busy;
    logic             done;
    logic             equal;
    logic [IDX_W-1:0] mismatch_idx;

    int total = 0;
    int bad   = 0;

    // Result the DUT should currently be holding.
    logic             m_equal = 1'b0;
    logic [IDX_W-1:0] m_idx   = '0;

    eqcmp_seq_ctrl #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_idx (mismatch_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_mismatch(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        for (int k = 0; k < CHUNKS; k++)
            if (a[k*WIDTH +: WIDTH] != b[k*WIDTH +: WIDTH]) return k;
        return CHUNKS;
    endfunction

    function automatic int done_cycle(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        int k;
        k = first_mismatch(a, b);
        return (k < CHUNKS) ? k + 2 : CHUNKS + 1;
    endfunction

    // Start a compare in the current cycle (cycle 0) and check every cycle through the IDLE after done.
    // In cycle dist_cycle the live operands become da/db, optionally with a start pulse and/or abort.
    task automatic run_compare(input string name, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                               input int dist_cycle, input logic [OPW-1:0] da, input logic [OPW-1:0] db,
                               input bit dist_start, input bit dist_abort);
        int               k;
        int               dc;
        logic             exp_eq;
        logic [IDX_W-1:0] exp_idx;
        logic             e_busy;
        logic             e_done;
        logic             e_equal;
        logic [IDX_W-1:0] e_idx;
        k       = first_mismatch(a, b);
        dc      = done_cycle(a, b);
        exp_eq  = (k == CHUNKS);
        exp_idx = exp_eq ? '0 : IDX_W'(k);
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        for (int c = 1; c <= dc + 1; c++) begin
            step();
            start   = 1'b0;
            abort   = 1'b0;
            e_busy  = (c <= dc);
            e_done  = (c == dc);
            e_equal = (c >= dc) ? exp_eq : m_equal;
            e_idx   = (c >= dc) ? exp_idx : m_idx;
            total++;
            if (busy !== e_busy) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got=%b exp=%b", name, c, busy, e_busy);
            end
            total++;
            if (done !== e_done) begin
                bad++;
                $display("FAIL %s done cycle %0d: got=%b exp=%b", name, c, done, e_done);
            end
            total++;
            if (equal !== e_equal) begin
                bad++;
                $display("FAIL %s equal cycle %0d: got=%b exp=%b", name, c, equal, e_equal);
            end
            total++;
            if (mismatch_idx !== e_idx) begin
                bad++;
                $display("FAIL %s mismatch_idx cycle %0d: got=%0d exp=%0d", name, c, mismatch_idx, e_idx);
            end
            if (c == dist_cycle) begin
                op_a  = da;
                op_b  = db;
                start = dist_start;
                if (dist_abort && c == dc) abort = 1'b1;
            end
        end
        start   = 1'b0;
        abort   = 1'b0;
        m_equal = exp_eq;
        m_idx   = exp_idx;
    endtask

    // Start a compare, raise abort during cycle ac (ac < done cycle); expect IDLE from ac+1, no done.
    task automatic run_abort(input string name, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                             input int ac);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        for (int c = 1; c <= ac + 4; c++) begin
            step();
            start = 1'b0;
            abort = 1'b0;
            total++;
            if (busy !== (c <= ac)) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got=%b exp=%b", name, c, busy, (c <= ac));
            end
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL %s done cycle %0d: got=%b exp=0", name, c, done);
            end
            total++;
            if (equal !== m_equal || mismatch_idx !== m_idx) begin
                bad++;
                $display("FAIL %s result cycle %0d: got=%b/%0d exp=%b/%0d",
                         name, c, equal, mismatch_idx, m_equal, m_idx);
            end
            if (c == ac) abort = 1'b1;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || equal !== 1'b0 || mismatch_idx !== '0) begin
                bad++;
                $display("FAIL reset_state: got busy=%b done=%b equal=%b idx=%0d exp all 0",
                         busy, done, equal, mismatch_idx);
            end
        end
        start = 1'b0;
        reset = 1'b0;
        step();
        m_equal = 1'b0;
        m_idx   = '0;
    endtask

    task automatic test_directed();
        run_compare("full_match", 32'hDEADBEEF, 32'hDEADBEEF, 0, '0, '0, 1'b0, 1'b0);
        run_compare("mismatch_c0", 32'h12345678, 32'h12345679, 0, '0, '0, 1'b0, 1'b0);
        run_compare("mismatch_c3_opchg", 32'hAA000000, 32'hAB000000, 2,
                    32'hAA000000, 32'hAA000000, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_compare("start_ignored", 32'hDEADBEEF, 32'hDEADBEEF, 3, 32'h1, 32'h2, 1'b1, 1'b0);
        run_compare("back_to_back", 32'h12345678, 32'h12345679, 0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_compare("pre_abort", 32'h12345678, 32'h12345679, 0, '0, '0, 1'b0, 1'b0);
        run_abort("abort_run", 32'hDEADBEEF, 32'hDEADBEEF, 2);
        // Abort in IDLE, then abort coinciding with start, then abort in DONE: all harmless.
        abort = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_abort busy: got=%b exp=0", busy);
        end
        abort = 1'b1;
        run_compare("abort_at_start", 32'hCAFE0001, 32'hCAFE0001, 0, '0, '0, 1'b0, 1'b0);
        run_compare("abort_in_done", 32'h00FF0000, 32'h00FE0000, 4,
                    32'h00FF0000, 32'h00FE0000, 1'b1, 1'b1);
    endtask

    task automatic test_reset_midrun();
        op_a  = 32'hDEADBEEF;
        op_b  = 32'hDEADBEEF;
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL reset_mid busy cycle %0d: got=%b exp=1", c, busy);
            end
            if (c == 3) reset = 1'b1;
        end
        step();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || equal !== 1'b0 || mismatch_idx !== '0) begin
            bad++;
            $display("FAIL reset_mid clear: got busy=%b done=%b equal=%b idx=%0d exp all 0",
                     busy, done, equal, mismatch_idx);
        end
        m_equal = 1'b0;
        m_idx   = '0;
        run_compare("after_reset", 32'h0BADF00D, 32'h1BADF00D, 0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        int             dc;
        int             mode;
        for (int it = 0; it < 60; it++) begin
            a = $urandom;
            b = a;
            for (int k = 0; k < CHUNKS; k++)
                if ($urandom_range(0, 3) == 0) b[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            dc   = done_cycle(a, b);
            mode = $urandom_range(0, 3);
            if (mode == 0)
                run_abort("rand_abort", a, b, $urandom_range(1, dc - 1));
            else
                run_compare("rand_cmp", a, b, $urandom_range(0, dc), $urandom, $urandom,
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eqcmp_seq_ctrl.md
Name: eqcmp_seq_ctrl

Overview:
Sequencer that checks two wide operands for equality by sending them one WIDTH-bit chunk per cycle through a single internal eqcmp instance. It stops early on the first mismatching chunk. It reports the result with a start/busy/done handshake. It serves CPU blocks that need wide equality checks (tag, vector and block compares) but cannot afford a full-width comparator.

Parameters:
WIDTH, 8, chunk width; also the width of the internal eqcmp instance.
CHUNKS, 4, number of chunks per operand; must be >= 2.
IDX_W, $clog2(CHUNKS), width of the chunk index (derived; not overridden).

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request a compare; sampled only in IDLE.
abort  in  1  cancel a compare in progress; acts only in RUN.
op_a  in  WIDTH*CHUNKS  operand A; chunk k = op_a[k*WIDTH +: WIDTH].
op_b  in  WIDTH*CHUNKS  operand B; same chunk layout.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse when a result is valid.
equal  out  1  1 = all chunks matched in the last completed compare.
mismatch_idx  out  IDX_W  index of the first mismatching chunk; 0 when equal=1.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state updates on rising clk.
- Reset (including mid-operation) forces: state=IDLE, busy=0, done=0, equal=0, mismatch_idx=0, internal idx=0, operand latches=0.
- FSM states: IDLE, RUN, DONE. done=1 only in DONE.
- IDLE:
  - start=1 latches op_a/op_b into internal registers, sets idx=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN: the eqcmp compares latched chunk idx of A and B every cycle. Priority is reset > abort > compare:
  - abort=1: go to IDLE. No done pulse. equal/mismatch_idx keep their prior values.
  - Chunk mismatch: equal<=0, mismatch_idx<=idx, go to DONE.
  - Chunk match and idx==CHUNKS-1: equal<=1, mismatch_idx<=0, go to DONE.
  - Chunk match otherwise: idx<=idx+1, stay in RUN.
- DONE: lasts exactly one cycle, then goes to IDLE. start and abort are ignored here.
- Latency, with start sampled at edge 0:
  - Mismatch at chunk k: done is high in cycle k+2.
  - Full match: done is high in cycle CHUNKS+1.
  - busy is high from cycle 1 through the done cycle inclusive.
- equal and mismatch_idx change only on entry to DONE. They hold from then until the next compare completes, so they are stable while busy and after done falls.
- Operands are consumed only from the latches. op_a/op_b changes after acceptance have no effect.
- start while busy=1 is ignored and not queued.
- Back-to-back operation: start asserted in the cycle after done (IDLE) is accepted. The minimum issue interval is therefore k+3 cycles.
- idx never exceeds CHUNKS-1. There is no wrap-around.
- abort in IDLE or DONE has no effect.

Test Plan:
1. WIDTH=8, CHUNKS=4. Reset, then op_a=op_b=32'hDEADBEEF with start for 1 cycle -> busy in cycles 1-5; done only in cycle 5; equal=1; mismatch_idx=0.
2. op_a=32'h12345678, op_b=32'h12345679 -> done in cycle 2; equal=0; mismatch_idx=0; busy high only in cycles 1-2.
3. op_a=32'hAA000000, op_b=32'hAB000000 -> done in cycle 5; equal=0; mismatch_idx=3. Then change op_b to equal op_a in cycle 2 -> result unchanged.
4. Start compare of test 1. Pulse start with op_a=1, op_b=2 in cycle 3 -> ignored; done in cycle 5 with equal=1. Start again in cycle 6 -> accepted; busy in cycle 7.
5. Complete test 2 (equal=0, idx=0). Start test 1 operands and assert abort in cycle 2 -> IDLE in cycle 3; done never pulses; equal=0 and mismatch_idx=0 retained.
6. Assert reset in cycle 3 of a full-match run -> next cycle busy=0, done=0, equal=0, mismatch_idx=0. A new start is accepted right after reset deasserts.
